// File: rtl/if_prefetch.sv
// Instruction fetch prefetcher: credit-limited in-order memory requests feeding a
// small instruction buffer, with redirect flush, response discard and sticky fault.
module if_prefetch #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IRAMSIZE = 131072
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_valid,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_data,
    input  logic        inst_ready,
    output logic        exception,
    output logic [31:0] fetch_pc
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int IW = $clog2(IRAMSIZE);
    localparam int DW = AW + 8;
    localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } entry_t;

    entry_t      buf_mem [DEPTH];
    logic [31:0] tag_mem [DEPTH];

    logic [31:0]   fetch_pc_q;
    logic [PW-1:0] wr_ptr, rd_ptr, tag_wr, tag_rd;
    logic [DW-1:0] disc_q, disc_d;
    logic          exc_q;

    logic [PW-1:0] buf_cnt, out_cnt;
    logic [PW:0]   credit_use;
    logic          buf_full, range_fault;
    logic          accept, push, pop, drop, resp_live, exc_set;

    assign buf_cnt    = wr_ptr - rd_ptr;
    assign out_cnt    = tag_wr - tag_rd;
    assign credit_use = {1'b0, buf_cnt} + {1'b0, out_cnt};
    assign buf_full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // Fault is raised from the address about to be presented, so it is never issued.
    assign range_fault = (fetch_pc_q >> IW) != 32'd0;

    assign imem_valid = !reset && !exc_q && !range_fault && (credit_use < DEPTH_C);
    assign imem_addr  = fetch_pc_q;
    assign fetch_pc   = fetch_pc_q;
    assign exception  = exc_q;

    assign accept    = imem_valid && imem_ready;
    assign resp_live = imem_rvalid && ((disc_q != '0) || (out_cnt != '0));
    assign drop      = imem_rvalid && (disc_q != '0);
    assign push      = imem_rvalid && (disc_q == '0) && (out_cnt != '0) && !buf_full;
    assign pop       = inst_valid && inst_ready;
    assign exc_set   = range_fault || (redirect_valid && (redirect_pc[1:0] != 2'b00));

    // Everything still in flight after this edge (old discards, live tags, a same-cycle
    // accept, minus the response consumed now) must be thrown away after a redirect.
    assign disc_d = disc_q + DW'(out_cnt) + DW'(accept) - DW'(resp_live);

    assign inst_valid = (wr_ptr != rd_ptr);
    assign inst_pc    = inst_valid ? buf_mem[rd_ptr[AW-1:0]].pc   : 32'd0;
    assign inst_data  = inst_valid ? buf_mem[rd_ptr[AW-1:0]].data : 32'd0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            tag_wr     <= '0;
            tag_rd     <= '0;
            disc_q     <= '0;
            exc_q      <= 1'b0;
        end else begin
            if (exc_set)
                exc_q <= 1'b1;
            if (redirect_valid) begin
                fetch_pc_q <= {redirect_pc[31:2], 2'b00};
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                tag_wr     <= '0;
                tag_rd     <= '0;
                disc_q     <= disc_d;
            end else begin
                if (accept) begin
                    fetch_pc_q <= fetch_pc_q + 32'd4;
                    tag_wr     <= tag_wr + PW'(1);
                end
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                    tag_rd <= tag_rd + PW'(1);
                end
                if (pop)
                    rd_ptr <= rd_ptr + PW'(1);
                if (drop)
                    disc_q <= disc_q - DW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept && !redirect_valid)
            tag_mem[tag_wr[AW-1:0]] <= fetch_pc_q;
        if (push && !redirect_valid)
            buf_mem[wr_ptr[AW-1:0]] <= '{pc: tag_mem[tag_rd[AW-1:0]], data: imem_rdata};
    end
endmodule

// File: tb/tb_if_prefetch.sv
// Directed bench for if_prefetch: per-cycle vector table plus hand sequences for
// stall, discard, fault and reset corner cases against a latency-modelled memory.
module tb_if_prefetch;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        imem_valid;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        inst_valid;
    logic [31:0] inst_pc, inst_data;
    logic        inst_ready = 1'b0;
    logic        exception;
    logic [31:0] fetch_pc;

    always #5 clk = ~clk;

    if_prefetch dut (
        .clk(clk), .reset(reset),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_valid(imem_valid), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst_pc(inst_pc), .inst_data(inst_data),
        .inst_ready(inst_ready), .exception(exception), .fetch_pc(fetch_pc)
    );

    int errs = 0;
    int checks = 0;
    int cyc = 0;
    int lat = 1;
    logic mem_rdy = 1'b1;

    logic [31:0] mq_addr[$];
    int          mq_due[$];
    logic [31:0] acc_q[$];
    logic [31:0] pop_pc[$];
    logic [31:0] pop_data[$];

    typedef struct packed {
        logic        ir;
        logic        rd;
        logic [31:0] rpc;
        logic        iv;
        logic [31:0] ipc;
        logic        mv;
        logic [31:0] ma;
    } vec_t;
    vec_t tbl[18];

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return ~a;
    endfunction

    function automatic logic [31:0] pp(input int i);
        return (pop_pc.size() > i) ? pop_pc[i] : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] pd(input int i);
        return (pop_data.size() > i) ? pop_data[i] : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] aq(input int i);
        return (acc_q.size() > i) ? acc_q[i] : 32'hFFFF_FFFF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drives memory inputs for the coming edge, logs accepts/pops, then advances one clock.
    task automatic cycle();
        imem_ready  = mem_rdy;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
        if (mq_due.size() > 0 && mq_due[0] == cyc + 1) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mdata(mq_addr[0]);
            mq_addr.delete(0);
            mq_due.delete(0);
        end
        if (imem_valid && mem_rdy) begin
            mq_addr.push_back(imem_addr);
            mq_due.push_back(cyc + 1 + lat);
            acc_q.push_back(imem_addr);
        end
        if (inst_valid && inst_ready) begin
            pop_pc.push_back(inst_pc);
            pop_data.push_back(inst_data);
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        redirect_valid = 1'b0;
        #1;
        chk("rst_imem_valid", 32'(imem_valid), 32'd0);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_exception", 32'(exception), 32'd0);
        chk("rst_fetch_pc", fetch_pc, 32'h0);
        chk("rst_imem_addr", imem_addr, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_inst_data", inst_data, 32'h0);
        mq_addr.delete();
        mq_due.delete();
        cycle();
        cycle();
        acc_q.delete();
        pop_pc.delete();
        pop_data.delete();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int mv_seen;
        //              ir    rd    rpc          iv    ipc          mv    ma
        tbl[0]  = '{1'b1, 1'b0, 32'h0,     1'b0, 32'h0,     1'b1, 32'h0};
        tbl[1]  = '{1'b1, 1'b0, 32'h0,     1'b0, 32'h0,     1'b1, 32'h4};
        tbl[2]  = '{1'b1, 1'b0, 32'h0,     1'b1, 32'h0,     1'b1, 32'h8};
        tbl[3]  = '{1'b1, 1'b0, 32'h0,     1'b1, 32'h4,     1'b1, 32'hC};
        tbl[4]  = '{1'b1, 1'b0, 32'h0,     1'b1, 32'h8,     1'b1, 32'h10};
        tbl[5]  = '{1'b0, 1'b0, 32'h0,     1'b1, 32'hC,     1'b1, 32'h14};
        tbl[6]  = '{1'b0, 1'b0, 32'h0,     1'b1, 32'hC,     1'b1, 32'h18};
        tbl[7]  = '{1'b0, 1'b0, 32'h0,     1'b1, 32'hC,     1'b0, 32'h1C};
        tbl[8]  = '{1'b0, 1'b0, 32'h0,     1'b1, 32'hC,     1'b0, 32'h1C};
        tbl[9]  = '{1'b1, 1'b0, 32'h0,     1'b1, 32'hC,     1'b0, 32'h1C};
        tbl[10] = '{1'b1, 1'b0, 32'h0,     1'b1, 32'h10,    1'b1, 32'h1C};
        tbl[11] = '{1'b1, 1'b0, 32'h0,     1'b1, 32'h14,    1'b1, 32'h20};
        tbl[12] = '{1'b1, 1'b0, 32'h0,     1'b1, 32'h18,    1'b1, 32'h24};
        tbl[13] = '{1'b1, 1'b1, 32'h200,   1'b1, 32'h1C,    1'b1, 32'h28};
        tbl[14] = '{1'b1, 1'b0, 32'h0,     1'b0, 32'h0,     1'b1, 32'h200};
        tbl[15] = '{1'b1, 1'b0, 32'h0,     1'b0, 32'h0,     1'b1, 32'h204};
        tbl[16] = '{1'b1, 1'b0, 32'h0,     1'b1, 32'h200,   1'b1, 32'h208};
        tbl[17] = '{1'b1, 1'b0, 32'h0,     1'b1, 32'h204,   1'b1, 32'h20C};

        // Streaming, stall/release and redirect with same-cycle accept and response.
        lat = 1; mem_rdy = 1'b1;
        do_reset();
        for (int i = 0; i < 18; i++) begin
            chk($sformatf("vec%0d_inst_valid", i), 32'(inst_valid), 32'(tbl[i].iv));
            chk($sformatf("vec%0d_inst_pc", i), inst_pc, tbl[i].ipc);
            chk($sformatf("vec%0d_inst_data", i), inst_data, tbl[i].iv ? mdata(tbl[i].ipc) : 32'd0);
            chk($sformatf("vec%0d_imem_valid", i), 32'(imem_valid), 32'(tbl[i].mv));
            chk($sformatf("vec%0d_imem_addr", i), imem_addr, tbl[i].ma);
            chk($sformatf("vec%0d_exception", i), 32'(exception), 32'd0);
            inst_ready     = tbl[i].ir;
            redirect_valid = tbl[i].rd;
            redirect_pc    = tbl[i].rpc;
            cycle();
            redirect_valid = 1'b0;
        end

        // Stalled decode: credit stops at four requests, then drains and resumes at 0x10.
        inst_ready = 1'b0;
        do_reset();
        repeat (8) cycle();
        chk("stall_accepts", 32'(acc_q.size()), 32'd4);
        chk("stall_imem_valid", 32'(imem_valid), 32'd0);
        acc_q.delete();
        inst_ready = 1'b1;
        for (int k = 0; k < 20 && pop_pc.size() < 4; k++) cycle();
        chk("drain_pops", 32'(pop_pc.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain_pc%0d", i), pp(i), 32'(4 * i));
            chk($sformatf("drain_data%0d", i), pd(i), mdata(32'(4 * i)));
        end
        chk("resume_addr", aq(0), 32'h10);

        // Latency 3, two outstanding, redirect: both stale responses are dropped.
        lat = 3;
        do_reset();
        cycle();
        cycle();
        chk("lat3_outstanding", 32'(acc_q.size()), 32'd2);
        mem_rdy = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        cycle();
        redirect_valid = 1'b0; mem_rdy = 1'b1;
        chk("lat3_flush_iv", 32'(inst_valid), 32'd0);
        chk("lat3_new_addr", imem_addr, 32'h100);
        for (int k = 0; k < 30 && pop_pc.size() < 2; k++) cycle();
        chk("lat3_first_pc", pp(0), 32'h100);
        chk("lat3_first_data", pd(0), mdata(32'h100));
        chk("lat3_second_pc", pp(1), 32'h104);
        lat = 1;

        // Misaligned redirect: sticky fault, no further requests until reset.
        do_reset();
        cycle();
        redirect_valid = 1'b1; redirect_pc = 32'h102;
        cycle();
        redirect_valid = 1'b0;
        chk("misalign_exception", 32'(exception), 32'd1);
        chk("misalign_imem_valid", 32'(imem_valid), 32'd0);
        mv_seen = 0;
        repeat (6) begin
            cycle();
            if (imem_valid) mv_seen++;
        end
        chk("misalign_no_requests", 32'(mv_seen), 32'd0);
        chk("misalign_sticky", 32'(exception), 32'd1);

        // Fetch runs into the end of instruction memory.
        do_reset();
        redirect_valid = 1'b1; redirect_pc = 32'h0001_FFF0;
        cycle();
        redirect_valid = 1'b0;
        acc_q.delete();
        repeat (12) cycle();
        chk("edge_accepts", 32'(acc_q.size()), 32'd4);
        chk("edge_last_accept", aq(3), 32'h0001_FFFC);
        chk("edge_pops", 32'(pop_pc.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("edge_pc%0d", i), pp(i), 32'h0001_FFF0 + 32'(4 * i));
        chk("edge_last_data", pd(3), mdata(32'h0001_FFFC));
        chk("edge_exception", 32'(exception), 32'd1);
        chk("edge_imem_valid", 32'(imem_valid), 32'd0);
        chk("edge_fetch_pc", fetch_pc, 32'h0002_0000);

        // Reset with three buffered entries, then a stale response before any accept.
        inst_ready = 1'b0;
        do_reset();
        repeat (4) cycle();
        chk("prerst_inst_valid", 32'(inst_valid), 32'd1);
        chk("prerst_inst_pc", inst_pc, 32'h0);
        mem_rdy = 1'b0;
        do_reset();
        mq_addr.push_back(32'hC);
        mq_due.push_back(cyc + 1);
        cycle();
        chk("stale_rvalid_iv", 32'(inst_valid), 32'd0);
        cycle();
        chk("stale_rvalid_iv2", 32'(inst_valid), 32'd0);
        mem_rdy = 1'b1;
        inst_ready = 1'b1;
        for (int k = 0; k < 10 && pop_pc.size() < 1; k++) cycle();
        chk("postrst_first_pc", pp(0), 32'h0);
        chk("postrst_first_data", pd(0), mdata(32'h0));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
